// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the CPU data bus.
// A two-word register window (TXDATA, STATUS) sits at BASE_ADDR. Bytes are
// queued in a small FIFO and shifted out LSB first on Tx.
// Optional build macro UART_PARITY_EN adds an even-parity bit before the
// stop bit and reports it in STATUS bit4.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Tx,
  output logic        Busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  localparam logic PARITY_ON = 1'b1;
`else
  localparam logic PARITY_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Register window decode
  logic hit;
  logic sel_txdata;
  logic sel_status;
  logic push_req;
  logic clr_ovf;

  // FIFO state
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             overflow;

  // Serialiser state
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic              baud_last;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tx_q;
`ifdef UART_PARITY_EN
  logic              parity_q;
`endif

  // Address bits [1:0] and the upper store-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{Address[1:0], WriteData[31:8]};

  assign hit        = (Address[31:3] == BASE_ADDR[31:3]);
  assign sel_txdata = hit && !Address[2];
  assign sel_status = hit &&  Address[2];
  assign push_req   = MemWrite && sel_txdata;
  assign clr_ovf    = MemWrite && sel_status && WriteData[3];

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A write into a full FIFO is dropped even if a pop frees a slot at the
  // same edge: fullness is judged on the pre-edge count.
  assign push = push_req && !full;
  assign pop  = (state == S_IDLE) && !empty;

  assign baud_last = (baud_cnt == BAUD_LAST);

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  // FIFO storage array
  always_ff @(posedge Clk) begin
    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, so stale contents are never observed.
    if (push) fifo_mem[wr_ptr] <= WriteData[7:0];
  end

  // Transmit FSM: baud timing, shift register and registered Tx
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE) baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);

      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
`ifdef UART_PARITY_EN
            parity_q  <= ^fifo_mem[rd_ptr];
`endif
            baud_cnt  <= '0;
            tx_q      <= 1'b0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (baud_last) begin
            bit_idx <= '0;
            tx_q    <= shift_reg[0];
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (baud_last) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q  <= parity_q;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              shift_reg <= shift_reg >> 1;
              tx_q      <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            tx_q  <= 1'b1;
            state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (baud_last) begin
            tx_q  <= 1'b1;
            state <= S_IDLE;
          end
        end

        default: begin
          tx_q  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign Tx   = tx_q;
  assign Busy = (state != S_IDLE) || !empty;

  // Status read path, muxed by the top level with data-memory read data
  always_comb begin
    // NOTE: defaulting ReadData first keeps every path assigned, so no latch
    // is inferred for addresses outside the STATUS register.
    ReadData = '0;
    if (sel_status) begin
      ReadData[0] = full;
      ReadData[1] = empty;
      ReadData[2] = (state != S_IDLE);
      ReadData[3] = overflow;
      ReadData[4] = PARITY_ON;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx.
// Stimulus pushes each byte it expects on the line into a queue; a monitor
// decodes every Tx frame cycle by cycle and compares against the queue head.
module tb_mmio_uart_tx;

  localparam int N = 4;
`ifdef UART_PARITY_EN
  localparam int          FB = 11;
  localparam logic [31:0] PB = 32'h10;
`else
  localparam int          FB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif
  localparam int FRAME_CYC = FB * N;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic        tx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];
  int  frames_done = 0;
  int  last_gap    = 0;
  int  prev_end    = -1000;
  bit  mon_busy    = 1'b0;
  int  cyc         = 0;

  // monitor working variables
  logic [7:0] m_exp;
  logic [7:0] m_got;
  int         m_bad;
  int         m_start;
  bit         m_abort;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_1000),
    .CLKS_PER_BIT(N),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .Address  (address),
    .WriteData(write_data),
    .MemWrite (mem_write),
    .ReadData (read_data),
    .Tx       (tx),
    .Busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    write_data = d;
    mem_write  = 1'b1;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    mem_write  = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address    = a;
    write_data = 32'h0;
    mem_write  = 1'b0;
    #1;
    check(name, read_data, exp);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !mon_busy && sb.size() == 0) done = 1'b1;
    end
    check({name, "_idle"}, 32'(done), 32'h1);
  endtask

  // Frame monitor: every cycle of each frame is compared with the expected bit
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_busy = 1'b1;
        m_start  = cyc;
        m_bad    = 0;
        m_got    = 8'h00;
        m_abort  = 1'b0;
        check("frame_expected", 32'(sb.size() > 0), 32'h1);
        m_exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        for (int c = 0; c < FRAME_CYC; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            m_abort = 1'b1;
            break;
          end
          if (tx !== exp_bit(m_exp, c / N)) m_bad++;
          if (c / N >= 1 && c / N <= 8 && c % N == N / 2) m_got[c/N-1] = tx;
        end
        if (!m_abort) begin
          check("frame_data", 32'(m_got), 32'(m_exp));
          check("frame_shape", 32'(m_bad), 32'h0);
          last_gap = m_start - prev_end;
          prev_end = m_start + FRAME_CYC;
          frames_done++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int f0;
    rst_n      = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    mem_write  = 1'b0;

    // Reset state and decode
    repeat (3) @(negedge clk);
    read_check(32'h1004, 32'h2 | PB, "reset_status");
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    read_check(32'h2000, 32'h0, "outside_window");
    read_check(32'h1006, 32'h2 | PB, "status_low_bits_ignored");
    read_check(32'h1000, 32'h0, "txdata_reads_zero");
    @(negedge clk);
    rst_n = 1'b1;
    read_check(32'h1004, 32'h2 | PB, "post_reset_status");

    // Single byte 0xA5: latency, frame timing, Busy fall
    sb.push_back(8'hA5);
    bus_write(32'h1000, 32'hA5);
    bus_idle();
    check("a5_tx_before_pop", 32'(tx), 32'h1);
    check("a5_busy_queued", 32'(busy), 32'h1);
    @(negedge clk);
    check("a5_start_low", 32'(tx), 32'h0);
    repeat (FRAME_CYC - 1) @(negedge clk);
    check("a5_busy_in_stop", 32'(busy), 32'h1);
    check("a5_tx_stop_high", 32'(tx), 32'h1);
    @(negedge clk);
    check("a5_busy_after", 32'(busy), 32'h0);
    wait_idle(50, "a5");

    // Back-to-back frames 0x55, 0x0F
    sb.push_back(8'h55);
    sb.push_back(8'h0F);
    bus_write(32'h1000, 32'h55);
    bus_write(32'h1000, 32'h0F);
    bus_idle();
    wait_idle(200, "b2b");
    check("b2b_gap", 32'(last_gap), 32'h1);
    read_check(32'h1004, 32'h2 | PB, "b2b_empty");

    // Six writes: first popped, four queued, sixth dropped
    f0 = frames_done;
    sb.push_back(8'h01);
    sb.push_back(8'h82);
    sb.push_back(8'hC3);
    sb.push_back(8'h34);
    sb.push_back(8'hF5);
    bus_write(32'h1000, 32'h01);
    bus_write(32'h1000, 32'h82);
    bus_write(32'h1000, 32'hC3);
    bus_write(32'h1000, 32'h34);
    bus_write(32'h1000, 32'hF5);
    bus_write(32'h1000, 32'h66);
    read_check(32'h1004, 32'h0D | PB, "six_full_ovf");
    bus_write(32'h1004, 32'h8);
    read_check(32'h1004, 32'h05 | PB, "six_ovf_cleared");
    wait_idle(400, "six");
    check("six_frame_count", 32'(frames_done - f0), 32'h5);
    read_check(32'h1004, 32'h2 | PB, "six_done_status");

    // Write while full at the same edge as the IDLE pop
    f0 = frames_done;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    sb.push_back(8'h44);
    sb.push_back(8'h55);
    bus_write(32'h1000, 32'h11);
    bus_write(32'h1000, 32'h22);
    bus_write(32'h1000, 32'h33);
    bus_write(32'h1000, 32'h44);
    bus_write(32'h1000, 32'h55);
    bus_idle();
    repeat (FRAME_CYC - 4) @(negedge clk);
    bus_write(32'h1000, 32'hEE);
    read_check(32'h1004, 32'h0C | PB, "collide_count3_ovf");
    bus_write(32'h1004, 32'h8);
    bus_idle();
    wait_idle(400, "collide");
    check("collide_frame_count", 32'(frames_done - f0), 32'h5);

    // Reset asserted mid-frame during DATA
    sb.push_back(8'h3C);
    sb.push_back(8'h81);
    sb.push_back(8'h42);
    bus_write(32'h1000, 32'h3C);
    bus_write(32'h1000, 32'h81);
    bus_write(32'h1000, 32'h42);
    bus_idle();
    repeat (12) @(negedge clk);
    #2;
    address = 32'h1004;
    rst_n   = 1'b0;
    sb.delete();
    #1;
    check("midreset_tx", 32'(tx), 32'h1);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_status", read_data, 32'h2 | PB);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames_done;
    repeat (100) @(negedge clk);
    check("midreset_no_frames", 32'(frames_done), 32'(f0));
    check("midreset_tx_idle", 32'(tx), 32'h1);
    read_check(32'h1004, 32'h2 | PB, "midreset_final_status");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
